sha256_msg_schedule: RTL and testbench



---
 rtl/sha256_msg_schedule.sv | 111 +++++++++++
 tb/tb_sha256_msg_schedule.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message-schedule generator: loads 16 big-endian words, then streams W_0..W_{ROUNDS-1}.
// A 16-word shift window holds W_t..W_{t+15}; each output handshake appends W_{t+16}.
module sha256_msg_schedule #(
   parameter int unsigned ROUNDS = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_word,
   output logic        w_valid,
   input  logic        w_ready,
   output logic [31:0] w_out,
   output logic [5:0]  w_index,
   output logic        busy
);

   localparam int unsigned WW = 32;
   localparam int unsigned TW = 6;
   localparam int unsigned LW = 4;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_EMIT = 2'd2;

   logic [1:0]    state;
   logic [1:0]    next_state;
   logic [WW-1:0] r [16];
   logic [LW-1:0] lcnt;
   logic [TW-1:0] t;
   logic          in_hs;
   logic          out_hs;
   logic          last_word;
   logic          last_round;
   logic [WW-1:0] w_new;

   function automatic logic [WW-1:0] ror(input logic [WW-1:0] x, input int unsigned n);
      return (x >> n) | (x << (WW - n));
   endfunction

   function automatic logic [WW-1:0] sigma0(input logic [WW-1:0] x);
      return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [WW-1:0] sigma1(input logic [WW-1:0] x);
      return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
   endfunction

   // Handshake qualifiers and the next schedule word W_{t+16}
   always_comb begin
      in_hs      = in_valid & in_ready;
      out_hs     = w_valid & w_ready;
      last_word  = (lcnt == LW'(15));
      last_round = (t == TW'(ROUNDS - 1));
      w_new      = sigma1(r[14]) + r[9] + sigma0(r[1]) + r[0];
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE: if (in_hs) next_state = S_LOAD;
         S_LOAD: if (in_hs && last_word) next_state = S_EMIT;
         S_EMIT: if (out_hs && last_round) next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   // Status flags registered from the next state so they line up with the state register
   always_ff @(posedge clk) begin
      if (rst) begin
         in_ready <= 1'b1;
         w_valid  <= 1'b0;
         busy     <= 1'b0;
      end else begin
         in_ready <= (next_state != S_EMIT);
         w_valid  <= (next_state == S_EMIT);
         busy     <= (next_state != S_IDLE);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) r[i] <= '0;
         lcnt <= '0;
         t    <= '0;
      end else if (in_hs) begin
         for (int i = 0; i < 15; i++) r[i] <= r[i+1];
         r[15] <= in_word;
         lcnt  <= lcnt + LW'(1);
         t     <= '0;
      end else if (out_hs) begin
         for (int i = 0; i < 15; i++) r[i] <= r[i+1];
         r[15] <= w_new;
         if (last_round) begin
            t    <= '0;
            lcnt <= '0;
         end else begin
            t <= t + TW'(1);
         end
      end
   end

   assign w_out   = r[0];
   assign w_index = t;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Directed bench for sha256_msg_schedule: "abc", zero and back-to-back blocks, backpressure,
// mid-operation reset, plus a ROUNDS=16 instance.
module tb_sha256_msg_schedule;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, w_valid, w_ready, busy;
   logic [31:0] in_word, w_out;
   logic [5:0]  w_index;

   logic        in_valid16, in_ready16, w_valid16, w_ready16, busy16;
   logic [31:0] in_word16, w_out16;
   logic [5:0]  w_index16;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] blk   [16];
   logic [31:0] exp_w [64];

   always #5 clk = ~clk;

   sha256_msg_schedule #(.ROUNDS(64)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
      .w_valid(w_valid), .w_ready(w_ready), .w_out(w_out), .w_index(w_index),
      .busy(busy)
   );

   sha256_msg_schedule #(.ROUNDS(16)) dut16 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid16), .in_ready(in_ready16), .in_word(in_word16),
      .w_valid(w_valid16), .w_ready(w_ready16), .w_out(w_out16), .w_index(w_index16),
      .busy(busy16)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] s0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
   endfunction

   function automatic logic [31:0] s1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
   endfunction

   task automatic compute_exp();
      for (int k = 0; k < 64; k++) begin
         if (k < 16) exp_w[k] = blk[k];
         else        exp_w[k] = s1(exp_w[k-2]) + exp_w[k-7] + s0(exp_w[k-15]) + exp_w[k-16];
      end
   endtask

   task automatic set_abc();
      for (int k = 0; k < 16; k++) blk[k] = 32'h0;
      blk[0]  = 32'h61626380;
      blk[15] = 32'h00000018;
      compute_exp();
      // Hand-derived first expanded words of the "abc" block
      exp_w[16] = 32'h61626380;
      exp_w[17] = 32'h000F0000;
      exp_w[18] = 32'h7DA86405;
      exp_w[19] = 32'h600003C6;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_words(input int n, input int vpct);
      int i = 0;
      int guard = 0;
      logic hs;
      while (i < n && guard < 1000) begin
         in_valid = ($urandom_range(99) < 32'(vpct));
         in_word  = in_valid ? blk[i] : $urandom;
         hs = in_valid && in_ready;
         tick();
         guard++;
         if (hs) i++;
      end
      in_valid = 1'b0;
      if (i < n) check("load_timeout", 32'(i), 32'(n));
   endtask

   task automatic collect(input int n, input int rpct, input string tag);
      int k = 0;
      int guard = 0;
      logic hs, v;
      logic [31:0] o;
      logic [5:0]  idx;
      while (k < n && guard < 2000) begin
         w_ready = ($urandom_range(99) < 32'(rpct));
         if (w_valid) check({tag, "_in_ready_emit"}, 32'(in_ready), 32'd0);
         v   = w_valid;
         hs  = w_valid && w_ready;
         o   = w_out;
         idx = w_index;
         if (hs) begin
            check($sformatf("%s_w%0d", tag, k), w_out, exp_w[k]);
            check($sformatf("%s_idx%0d", tag, k), 32'(w_index), 32'(k));
         end
         tick();
         guard++;
         if (v && !hs) begin
            check({tag, "_hold_out"}, w_out, o);
            check({tag, "_hold_idx"}, 32'(w_index), 32'(idx));
         end
         if (hs) k++;
      end
      w_ready = 1'b0;
      if (k < n) check({tag, "_collect_timeout"}, 32'(k), 32'(n));
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      check({tag, "_w_valid"},  32'(w_valid),  32'd0);
      check({tag, "_busy"},     32'(busy),     32'd0);
   endtask

   task automatic run_block(input int vpct, input int rpct, input string tag);
      load_words(16, vpct);
      check({tag, "_first_valid"}, 32'(w_valid), 32'd1);
      check({tag, "_busy"}, 32'(busy), 32'd1);
      collect(64, rpct, tag);
      check_idle({tag, "_end"});
   endtask

   initial begin
      in_valid16 = 1'b0; in_word16 = '0; w_ready16 = 1'b0;
      w_ready = 1'b0; in_valid = 1'b0; in_word = '0;

      // Reset with random inputs
      rst = 1'b1;
      for (int c = 0; c < 2; c++) begin
         in_valid = 1'($urandom); in_word = $urandom; w_ready = 1'($urandom);
         tick();
      end
      check_idle("reset");
      check("reset_w_out", w_out, 32'h0);
      check("reset_w_index", 32'(w_index), 32'd0);
      rst = 1'b0; in_valid = 1'b0; w_ready = 1'b0;
      tick();

      set_abc();
      run_block(100, 100, "abc");

      for (int k = 0; k < 16; k++) blk[k] = 32'h0;
      compute_exp();
      run_block(100, 100, "zero");
      for (int k = 0; k < 16; k++) blk[k] = 32'h01010101 * 32'(k) + 32'h80000001;
      compute_exp();
      run_block(100, 100, "b2b");

      set_abc();
      run_block(60, 60, "bp");

      // Reset after 7 loaded words discards them
      for (int k = 0; k < 16; k++) blk[k] = 32'hDEADBEEF ^ 32'(k);
      load_words(7, 100);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_idle("rst_load");
      check("rst_load_w_out", w_out, 32'h0);
      set_abc();
      run_block(100, 100, "after_rst");

      // Reset while emitting at t=30
      load_words(16, 100);
      collect(30, 100, "mid");
      check("mid_t30", 32'(w_index), 32'd30);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_idle("rst_emit");
      check("rst_emit_w_out", w_out, 32'h0);
      check("rst_emit_w_index", 32'(w_index), 32'd0);

      // ROUNDS=16 instance emits exactly the loaded words
      check("r16_in_ready", 32'(in_ready16), 32'd1);
      for (int k = 0; k < 16; k++) begin
         in_valid16 = 1'b1;
         in_word16  = blk[k];
         tick();
      end
      in_valid16 = 1'b0;
      w_ready16  = 1'b1;
      for (int k = 0; k < 16; k++) begin
         check($sformatf("r16_valid%0d", k), 32'(w_valid16), 32'd1);
         check($sformatf("r16_w%0d", k), w_out16, blk[k]);
         check($sformatf("r16_idx%0d", k), 32'(w_index16), 32'(k));
         tick();
      end
      w_ready16 = 1'b0;
      check("r16_end_w_valid", 32'(w_valid16), 32'd0);
      check("r16_end_in_ready", 32'(in_ready16), 32'd1);
      check("r16_end_busy", 32'(busy16), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
